// File: rtl/adda_capture_buffer.sv
// Two-channel ADC capture: registers the sample pair, waits for a rising-edge
// level trigger on channel A, decimates and stores one record in a FIFO.
module adda_capture_buffer #(
    parameter int DATA_WIDTH  = 14,
    parameter int FIFO_DEPTH  = 512,
    parameter int SAMPLE_RATE = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [DATA_WIDTH-1:0]         adc_dataA_in,
    input  logic [DATA_WIDTH-1:0]         adc_dataB_in,
    input  logic                          adc_valid_in,
    input  logic                          arm_in,
    input  logic [DATA_WIDTH-1:0]         trig_level_in,
    input  logic                          rd_en_in,
    output logic [2*DATA_WIDTH-1:0]       rd_data_out,
    output logic                          rd_valid_out,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          overflow_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (SAMPLE_RATE > 0) ? SAMPLE_RATE : 1;
    localparam int RW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] a_p1, b_p1, prev_a;
    logic                  vld_p1;
    logic                  prev_valid, pv_nxt;
    logic [DW-1:0]         dec_cnt, dec_nxt;
    logic [CW-1:0]         wr_cnt, wr_nxt;
    logic                  ovf_nxt;
    logic                  keep, load_prev, wr_en, rd_fire;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [RW-1:0]         mem [FIFO_DEPTH];

    // ---- Stage 1: input register ----
    always_ff @(posedge clk_in) begin
        if (rst_in) vld_p1 <= 1'b0;
        else        vld_p1 <= adc_valid_in;
    end

    always_ff @(posedge clk_in) begin
        a_p1 <= adc_dataA_in;
        b_p1 <= adc_dataB_in;
        if (load_prev) prev_a <= a_p1;
    end

    // ---- Stage 2: trigger / decimation control on S1 samples ----
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            prev_valid   <= 1'b0;
            dec_cnt      <= '0;
            wr_cnt       <= '0;
            overflow_out <= 1'b0;
        end else begin
            state        <= state_nxt;
            prev_valid   <= pv_nxt;
            dec_cnt      <= dec_nxt;
            wr_cnt       <= wr_nxt;
            overflow_out <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pv_nxt    = prev_valid;
        dec_nxt   = dec_cnt;
        wr_nxt    = wr_cnt;
        ovf_nxt   = overflow_out;
        keep      = 1'b0;
        load_prev = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (state == IDLE || arm_in) begin
                    pv_nxt  = 1'b0;
                    dec_nxt = '0;
                    wr_nxt  = '0;
                    ovf_nxt = 1'b0;
                end
                if (arm_in) state_nxt = ARMED;
            end
            ARMED: begin
                if (vld_p1) begin
                    load_prev = 1'b1;
                    pv_nxt    = 1'b1;
                    if (prev_valid && (prev_a < trig_level_in) && (a_p1 >= trig_level_in)) begin
                        keep      = 1'b1;
                        state_nxt = CAPTURE;
                        // Trigger sample occupies decimation slot 0.
                        dec_nxt   = DW'(1);
                    end
                end
            end
            CAPTURE: begin
                if (vld_p1) begin
                    dec_nxt = dec_cnt + 1'b1;
                    keep    = (SAMPLE_RATE == 0) || (dec_cnt == '0);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Kept samples advance the record even when the FIFO drops them.
        if (keep) begin
            wr_nxt = wr_cnt + 1'b1;
            if (wr_cnt == CW'(FIFO_DEPTH - 1)) state_nxt = DONE;
            if (fifo_full) ovf_nxt = 1'b1;
        end
    end

    assign busy_out   = (state == ARMED) || (state == CAPTURE);
    assign done_out   = (state == DONE);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign wr_en      = keep && !fifo_full;
    assign rd_fire    = rd_en_in && !fifo_empty;

    // ---- Stage 3: FIFO write and registered read ----
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_ptr] <= {b_p1, a_p1};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            rd_valid_out <= 1'b0;
            rd_data_out  <= '0;
        end else begin
            rd_valid_out <= rd_fire;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) begin
                rd_ptr      <= rd_ptr + 1'b1;
                rd_data_out <= mem[rd_ptr];
            end
            case ({wr_en, rd_fire})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_adda_capture_buffer.sv
// Bench for adda_capture_buffer: a 512-deep/decimate-by-4 instance and an
// 8-deep/no-decimation instance, checked against a scoreboard of expected words.
module tb_adda_capture_buffer;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, valid, arm, rd_en_a, rd_en_b;
    logic [13:0] da, db, lvl;

    logic [27:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, full_a, empty_a, busy_a, done_a, ovf_a;
    logic        rd_valid_b, full_b, empty_b, busy_b, done_b, ovf_b;
    logic [9:0]  cnt_a;
    logic [3:0]  cnt_b;

    int          checks = 0;
    int          errors = 0;
    logic [27:0] qa[$];
    logic [27:0] qb[$];
    logic [27:0] exp_a, exp_b, last_a, last_b;

    always #5 clk = ~clk;

    adda_capture_buffer #(.DATA_WIDTH(14), .FIFO_DEPTH(512), .SAMPLE_RATE(2)) dut_a (
        .clk_in(clk), .rst_in(rst_a), .adc_dataA_in(da), .adc_dataB_in(db),
        .adc_valid_in(valid), .arm_in(arm), .trig_level_in(lvl), .rd_en_in(rd_en_a),
        .rd_data_out(rd_data_a), .rd_valid_out(rd_valid_a), .fifo_full(full_a),
        .fifo_empty(empty_a), .fifo_count(cnt_a), .busy_out(busy_a),
        .done_out(done_a), .overflow_out(ovf_a)
    );

    adda_capture_buffer #(.DATA_WIDTH(14), .FIFO_DEPTH(8), .SAMPLE_RATE(0)) dut_b (
        .clk_in(clk), .rst_in(rst_b), .adc_dataA_in(da), .adc_dataB_in(db),
        .adc_valid_in(valid), .arm_in(arm), .trig_level_in(lvl), .rd_en_in(rd_en_b),
        .rd_data_out(rd_data_b), .rd_valid_out(rd_valid_b), .fifo_full(full_b),
        .fifo_empty(empty_b), .fifo_count(cnt_b), .busy_out(busy_b),
        .done_out(done_b), .overflow_out(ovf_b)
    );

    // Scoreboard: every read pulse must match the oldest expected word.
    always @(posedge clk) begin
        #1;
        if (rd_valid_a) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL rd_a_unexpected got=%h required=none", rd_data_a);
            end else begin
                exp_a = qa.pop_front();
                if (rd_data_a !== exp_a) begin
                    errors++;
                    $display("FAIL rd_a_data got=%h required=%h", rd_data_a, exp_a);
                end
            end
        end
        if (rd_valid_b) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL rd_b_unexpected got=%h required=none", rd_data_b);
            end else begin
                exp_b = qb.pop_front();
                if (rd_data_b !== exp_b) begin
                    errors++;
                    $display("FAIL rd_b_data got=%h required=%h", rd_data_b, exp_b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input logic v);
        da    = 14'(a);
        db    = 14'(a + 1000);
        valid = v;
        step();
    endtask

    function automatic logic [27:0] word(input int a);
        return {14'(a + 1000), 14'(a)};
    endfunction

    task automatic test_reset();
        rst_a = 1; rst_b = 1; arm = 0; valid = 0; rd_en_a = 0; rd_en_b = 0;
        lvl = 14'd100; da = 0; db = 0;
        step(); step();
        checks++;
        if ({busy_a, done_a, ovf_a, full_a, rd_valid_a, empty_a} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags got=%b required=000001",
                     {busy_a, done_a, ovf_a, full_a, rd_valid_a, empty_a});
        end
        checks++;
        if (cnt_a !== 10'd0 || rd_data_a !== 28'd0) begin
            errors++;
            $display("FAIL reset_count_data got=%0d/%h required=0/0", cnt_a, rd_data_a);
        end
        rst_a = 0;
        for (int i = 0; i < 10; i++) begin
            drive(90 + 5 * i, 1'b1);
            checks++;
            if (empty_a !== 1'b1 || cnt_a !== 10'd0 || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_write got=%b/%0d/%b required=1/0/0", empty_a, cnt_a, busy_a);
            end
        end
    endtask

    task automatic test_trigger_decimation();
        int pushed = 0;
        int n = 0;
        rst_a = 1; valid = 0; step(); rst_a = 0;
        qa.delete();
        arm = 1; step(); arm = 0;
        // Ramp 90,95,100,...: 100 is the first sample above threshold after a
        // lower one, so it is word 0 and every 4th sample after it is kept.
        for (int i = 0; i < 2100; i++) begin
            if (i >= 2 && (i - 2) % 4 == 0 && pushed < 512) begin
                qa.push_back(word(90 + 5 * i));
                last_a = word(90 + 5 * i);
                pushed++;
            end
            drive(90 + 5 * i, 1'b1);
            if (i == 10) begin
                checks++;
                if (busy_a !== 1'b1 || done_a !== 1'b0) begin
                    errors++;
                    $display("FAIL capture_busy got=%b/%b required=1/0", busy_a, done_a);
                end
            end
        end
        valid = 0; step(); step();
        checks++;
        if ({done_a, busy_a, full_a, ovf_a} !== 4'b1010 || cnt_a !== 10'd512) begin
            errors++;
            $display("FAIL record_done got=%b cnt=%0d required=1010 cnt=512",
                     {done_a, busy_a, full_a, ovf_a}, cnt_a);
        end
        rd_en_a = 1;
        while (qa.size() > 0 && n < 600) begin
            step();
            n++;
        end
        rd_en_a = 0; step(); step();
        checks++;
        if (qa.size() != 0 || empty_a !== 1'b1 || rd_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL drain_a got=left %0d empty %b valid %b required=0/1/0",
                     qa.size(), empty_a, rd_valid_a);
        end
        checks++;
        if (rd_data_a !== last_a) begin
            errors++;
            $display("FAIL rd_data_hold_a got=%h required=%h", rd_data_a, last_a);
        end
        arm = 1; step(); arm = 0;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL rearm_done got=%b/%b required=0/1", done_a, busy_a);
        end
    endtask

    task automatic test_no_false_trigger();
        rst_a = 1; valid = 0; step(); rst_a = 0;
        qa.delete();
        arm = 1; step(); arm = 0;
        for (int i = 0; i < 10; i++) drive(200, 1'b1);
        valid = 0; step(); step();
        checks++;
        if (busy_a !== 1'b1 || cnt_a !== 10'd0) begin
            errors++;
            $display("FAIL no_false_trigger got=%b/%0d required=1/0", busy_a, cnt_a);
        end
        drive(50, 1'b1);
        qa.push_back(word(150));
        drive(150, 1'b1);
        valid = 0; step(); step(); step();
        checks++;
        if (cnt_a !== 10'd1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL late_trigger got=%0d/%b required=1/1", cnt_a, busy_a);
        end
        rd_en_a = 1; step(); rd_en_a = 0; step(); step();
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL late_trigger_read got=left %0d required=0", qa.size());
        end
        rst_a = 1; step();
    endtask

    task automatic test_overflow();
        int n = 0;
        rst_b = 1; valid = 0; step(); rst_b = 0;
        qb.delete();
        arm = 1; step(); arm = 0;
        drive(50, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                qb.push_back(word(150 + i));
                last_b = word(150 + i);
            end
            drive(150 + i, 1'b1);
        end
        valid = 0; step(); step();
        checks++;
        if ({done_b, full_b, ovf_b} !== 3'b110 || cnt_b !== 4'd8) begin
            errors++;
            $display("FAIL first_record got=%b cnt=%0d required=110 cnt=8", {done_b, full_b, ovf_b}, cnt_b);
        end
        arm = 1; step(); arm = 0;
        drive(50, 1'b1);
        for (int i = 0; i < 8; i++) drive(160 + i, 1'b1);
        valid = 0; step(); step();
        checks++;
        if ({done_b, ovf_b} !== 2'b11 || cnt_b !== 4'd8) begin
            errors++;
            $display("FAIL overflow got=%b cnt=%0d required=11 cnt=8", {done_b, ovf_b}, cnt_b);
        end
        rd_en_b = 1;
        while (qb.size() > 0 && n < 20) begin
            step();
            n++;
        end
        rd_en_b = 0; step(); step();
        checks++;
        if (qb.size() != 0 || rd_valid_b !== 1'b0 || rd_data_b !== last_b) begin
            errors++;
            $display("FAIL overflow_readback got=left %0d valid %b data %h required=0/0/%h",
                     qb.size(), rd_valid_b, rd_data_b, last_b);
        end
    endtask

    task automatic test_concurrent();
        rst_b = 1; valid = 0; step(); rst_b = 0;
        qb.delete();
        arm = 1; step(); arm = 0;
        rd_en_b = 1;
        drive(50, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) qb.push_back(word(150 + i));
            drive(150 + i, 1'b1);
            checks++;
            if (cnt_b > 4'd1 || ovf_b !== 1'b0) begin
                errors++;
                $display("FAIL concurrent_count got=%0d/%b required<=1/0", cnt_b, ovf_b);
            end
        end
        valid = 0; step(); step(); step();
        rd_en_b = 0;
        checks++;
        if (qb.size() != 0 || done_b !== 1'b1 || ovf_b !== 1'b0 || empty_b !== 1'b1) begin
            errors++;
            $display("FAIL concurrent_end got=left %0d done %b ovf %b empty %b required=0/1/0/1",
                     qb.size(), done_b, ovf_b, empty_b);
        end
    endtask

    task automatic test_reset_mid();
        rst_b = 1; valid = 0; step(); rst_b = 0;
        qb.delete();
        arm = 1; step(); arm = 0;
        drive(50, 1'b1);
        drive(150, 1'b1);
        drive(151, 1'b1);
        drive(152, 1'b1);
        valid = 0;
        checks++;
        if (busy_b !== 1'b1 || cnt_b == 4'd0) begin
            errors++;
            $display("FAIL pre_reset_capture got=%b/%0d required=1/nonzero", busy_b, cnt_b);
        end
        rst_b = 1; step(); rst_b = 0;
        checks++;
        if ({busy_b, done_b, empty_b, full_b} !== 4'b0010 || cnt_b !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset got=%b cnt=%0d required=0010 cnt=0", {busy_b, done_b, empty_b, full_b}, cnt_b);
        end
        rd_en_b = 1; step(); rd_en_b = 0;
        checks++;
        if (rd_valid_b !== 1'b0 || cnt_b !== 4'd0) begin
            errors++;
            $display("FAIL empty_read got=%b/%0d required=0/0", rd_valid_b, cnt_b);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_trigger_decimation();
        test_no_false_trigger();
        test_overflow();
        test_concurrent();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
